// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM states, duty/quotient widths,
// and the saturating duty helper.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DUTY_W = 10;
  localparam int QUO_W  = 11;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 10'd1023;

  // A full-scale quotient (1024) folds onto the largest representable duty code.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [QUO_W-1:0] q);
    return q[QUO_W-1] ? DUTY_FULL : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider: the quotient of an 11-bit result is formed one bit per cycle.
// The last iteration raises done together with the final quotient; abort kills a running divide.
module pwm_div
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W+DUTY_W-1:0] dividend,
  input  logic [CNT_W-1:0]        divisor,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [QUO_W-1:0]        quotient
);

  logic [CNT_W:0]    rem;
  logic [DUTY_W-1:0] lo;
  logic [CNT_W-1:0]  dvs;
  logic [QUO_W-1:0]  quo;
  logic [3:0]        iter;
  logic              zero_div;

  logic              ge;
  logic [CNT_W:0]    rem_sub;
  logic [QUO_W-1:0]  quo_nxt;

  always_comb begin
    ge       = (rem >= {1'b0, dvs});
    rem_sub  = ge ? (rem - {1'b0, dvs}) : rem;
    quo_nxt  = {quo[QUO_W-2:0], ge};
    done     = busy && (iter == 4'd1);
    quotient = zero_div ? {1'b0, DUTY_FULL} : quo_nxt;
  end

  // rem_sub is always below the divisor, so dropping its top bit before the shift is lossless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      lo       <= '0;
      dvs      <= '0;
      quo      <= '0;
      iter     <= '0;
      zero_div <= 1'b0;
      busy     <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      iter <= '0;
    end else if (start) begin
      rem      <= {1'b0, dividend[CNT_W+DUTY_W-1:DUTY_W]};
      lo       <= dividend[DUTY_W-1:0];
      dvs      <= divisor;
      quo      <= '0;
      iter     <= 4'd11;
      zero_div <= (divisor == '0);
      busy     <= 1'b1;
    end else if (busy) begin
      rem  <= {rem_sub[CNT_W-1:0], lo[DUTY_W-1]};
      lo   <= {lo[DUTY_W-2:0], 1'b0};
      quo  <= quo_nxt;
      iter <= iter - 4'd1;
      if (iter == 4'd1) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and 10-bit duty of an asynchronous PWM pin; reports stuck input on timeout.
// Optional glitch filter after the synchronizer is enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 200_000,
  parameter int FILTER_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic              valid,
  output logic              stuck,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_q;
  logic       rise;
  logic       fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], pwm_in};
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt;
  logic          flt_lvl;

  // Any sample matching the current level restarts the run, so short pulses never propagate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_cnt <= '0;
      flt_lvl <= 1'b0;
    end else if (sync_q[1] == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      flt_lvl <= sync_q[1];
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
  assign lvl = flt_lvl;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

  logic [CNT_W-1:0] idle_cnt;
  logic             tmo;

  assign tmo = !(rise || fall) && (idle_cnt == TMO_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                idle_cnt <= '0;
    else if (rise || fall)  idle_cnt <= '0;
    else if (idle_cnt != TMO) idle_cnt <= idle_cnt + 1'b1;
  end

  state_t state_q, state_d;
  logic   cnt_restart, latch, per_inc, hi_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = ARM;
    end else begin
      case (state_q)
        ARM:     if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
        LOW:     if (rise) state_d = HIGH;
        default: state_d = ARM;
      endcase
    end
  end

  // hi_cnt stops on the fall cycle so it counts exactly the cycles the level was high.
  always_comb begin
    cnt_restart = rise && (state_q == ARM || state_q == LOW);
    latch       = rise && (state_q == LOW) && !busy;
    per_inc     = (state_q != ARM);
    hi_inc      = (state_q == HIGH) && !fall;
  end

  logic [CNT_W-1:0] per_cnt, hi_cnt, per_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      per_lat <= '0;
    end else begin
      if (cnt_restart) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
      end else begin
        if (per_inc && per_cnt != '1) per_cnt <= per_cnt + 1'b1;
        if (hi_inc && hi_cnt != '1)   hi_cnt  <= hi_cnt + 1'b1;
      end
      if (latch) per_lat <= per_cnt;
    end
  end

  logic             div_done;
  logic [QUO_W-1:0] div_q;

  pwm_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (latch),
    .dividend ({hi_cnt, {DUTY_W{1'b0}}}),
    .divisor  (per_cnt),
    .abort    (tmo),
    .busy     (busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty   <= '0;
      period <= '0;
      stuck  <= 1'b0;
      valid  <= 1'b0;
    end else if (tmo) begin
      duty   <= lvl ? DUTY_FULL : '0;
      period <= '0;
      stuck  <= 1'b1;
      valid  <= 1'b1;
    end else if (div_done) begin
      duty   <= sat_duty(div_q);
      period <= per_lat;
      stuck  <= 1'b0;
      valid  <= 1'b1;
    end else begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: waveform-level model of expected reports, checked every cycle.
module tb_pwm_capture;

  localparam int CNT_W      = 20;
  localparam int TIMEOUT    = 5000;
  localparam int FILTER_LEN = 4;
  localparam int DIV_CYC    = 12;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int MINW   = FILTER_LEN;
  localparam int B2B_D0 = 1019;
  localparam int B2B_D1 = 4;
`else
  localparam int MINW   = 1;
  localparam int B2B_D0 = 1022;
  localparam int B2B_D1 = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [9:0]       duty;
  logic [CNT_W-1:0] period;
  logic             valid, stuck, busy;

  pwm_capture #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty), .period(period),
    .valid(valid), .stuck(stuck), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int per;
    int duty;
    int stk;
  } rep_t;

  rep_t exp_q[$];
  rep_t obs_q[$];
  rep_t e_cur;

  int checks = 0;
  int errors = 0;

  // Waveform model: pin-level rise/fall times decide what the block must report.
  bit have_prev;
  int prev_rise, fall_t, last_acc;
  int hold_per, hold_duty, hold_stk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int duty_of(input int hi, input int per);
    int q;
    q = (hi * 1024) / per;
    return (q > 1023) ? 1023 : q;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    have_prev = 0;
    last_acc  = -100000;
    hold_per  = 0;
    hold_duty = 0;
    hold_stk  = 0;
  endtask

  task automatic model_rise();
    if (have_prev && (cyc - last_acc >= DIV_CYC)) begin
      exp_q.push_back('{per: cyc - prev_rise,
                        duty: duty_of(fall_t - prev_rise, cyc - prev_rise), stk: 0});
      last_acc = cyc;
    end
    have_prev = 1;
    prev_rise = cyc;
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    model_rise();
    step(h);
    pwm_in = 1'b0;
    fall_t = cyc;
    step(l);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    pwm_in = 1'b0;
    model_clear();
    step(3);
    rst = 1'b0;
    step(3);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid) begin
        obs_q.push_back('{per: int'(period), duty: int'(duty), stk: int'(stuck)});
        check("busy_at_valid", int'(busy), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got period %0d duty %0d stuck %0d, expected none (cycle %0d)",
                   period, duty, stuck, cyc);
        end else begin
          e_cur = exp_q.pop_front();
          check("period", int'(period), e_cur.per);
          check("duty", int'(duty), e_cur.duty);
          check("stuck", int'(stuck), e_cur.stk);
          hold_per  = e_cur.per;
          hold_duty = e_cur.duty;
          hold_stk  = e_cur.stk;
        end
      end else begin
        check("hold_period", int'(period), hold_per);
        check("hold_duty", int'(duty), hold_duty);
        check("hold_stuck", int'(stuck), hold_stk);
      end
    end
  end

  int n0, k;

  initial begin
    pwm_in = 1'b0;
    rst    = 1'b0;
    model_clear();
    #1 rst = 1'b1;
    step(3);
    check("rst_duty", int'(duty), 0);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_stuck", int'(stuck), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step(3);

    // 25 kHz, duty 750 from the motor generator: 4001-cycle period, 2929 high.
    n0 = obs_q.size();
    repeat (5) pulse(2929, 1072);
    step(30);
    check("pwm25k_count", obs_q.size() - n0, 4);
    check("pwm25k_duty", obs_q[$].duty, 749);
    check("pwm25k_period", obs_q[$].per, 4001);

    // Back-to-back duty change across two consecutive 1000-cycle periods.
    do_reset();
    n0 = obs_q.size();
    pulse(1000 - MINW, MINW);
    pulse(MINW, 1000 - MINW);
    pulse(500, 500);
    step(30);
    check("b2b_count", obs_q.size() - n0, 2);
    if (obs_q.size() - n0 == 2) begin
      check("b2b_duty0", obs_q[n0].duty, B2B_D0);
      check("b2b_duty1", obs_q[n0 + 1].duty, B2B_D1);
      check("b2b_period", obs_q[n0 + 1].per, 1000);
    end

    // Period shorter than the divide: every other rise is dropped.
    do_reset();
    n0 = obs_q.size();
    repeat (12) pulse(4, 4);
    step(30);
    check("short_count", obs_q.size() - n0, 6);
    check("short_duty", obs_q[$].duty, 512);
    check("short_period", obs_q[$].per, 8);

    // Stuck high, then stuck low; re-arm needs two rises afterwards.
    do_reset();
    pulse(100, 100);
    pulse(100, 100);
    n0 = obs_q.size();
    pwm_in = 1'b1;
    model_rise();
    exp_q.push_back('{per: 0, duty: 1023, stk: 1});
    have_prev = 0;
    step(TIMEOUT + 10);
    pwm_in = 1'b0;
    fall_t = cyc;
    exp_q.push_back('{per: 0, duty: 0, stk: 1});
    step(TIMEOUT + 10);
    check("stuck_count", obs_q.size() - n0, 3);
    if (obs_q.size() - n0 == 3) begin
      check("stuck_hi_duty", obs_q[n0 + 1].duty, 1023);
      check("stuck_hi_flag", obs_q[n0 + 1].stk, 1);
      check("stuck_hi_period", obs_q[n0 + 1].per, 0);
      check("stuck_lo_duty", obs_q[n0 + 2].duty, 0);
    end
    n0 = obs_q.size();
    repeat (3) pulse(100, 100);
    step(30);
    check("rearm_count", obs_q.size() - n0, 2);

    // Reset while the divider is running.
    do_reset();
    pulse(10, 10);
    pwm_in = 1'b1;
    model_rise();
    k = 0;
    while (!busy && k < 20) begin
      step(1);
      k++;
    end
    check("busy_seen", int'(busy), 1);
    rst    = 1'b1;
    pwm_in = 1'b0;
    model_clear();
    #1;
    check("mid_rst_duty", int'(duty), 0);
    check("mid_rst_period", int'(period), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_stuck", int'(stuck), 0);
    check("mid_rst_busy", int'(busy), 0);
    step(3);
    rst = 1'b0;
    step(3);
    n0 = obs_q.size();
    repeat (3) pulse(10, 10);
    step(30);
    check("post_rst_count", obs_q.size() - n0, 2);

`ifdef PWM_CAPTURE_FILTER_EN
    // 2-cycle glitch in the low phase must not disturb the measurement.
    do_reset();
    n0 = obs_q.size();
    pulse(30, 30);
    pwm_in = 1'b1;
    model_rise();
    step(30);
    pwm_in = 1'b0;
    fall_t = cyc;
    step(10);
    pwm_in = 1'b1;
    step(2);
    pwm_in = 1'b0;
    step(18);
    pulse(30, 30);
    pulse(30, 30);
    step(30);
    check("glitch_count", obs_q.size() - n0, 3);
    check("glitch_duty", obs_q[$].duty, 512);
`endif

    step(20);
    check("pending_reports", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
